// File: rtl/seq_link_pkg.sv
// seq_link_pkg: constants and state type shared by the serial link transmitter and detector.
package seq_link_pkg;
    localparam logic [3:0] PREAMBLE    = 4'b1011;
    localparam int         PREAMBLE_W  = 4;
    localparam int         DEFAULT_DIV = 3;
    typedef enum logic [1:0] {IDLE, ARMED, SHIFT} state_t;
endpackage

// File: rtl/seq_bit_tick.sv
// seq_bit_tick: free-running modulo-DIV counter; tick marks the last clk of each bit period.
module seq_bit_tick #(
    parameter int DIV = 3
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int W = $clog2(DIV);
    logic [W-1:0] cnt_q;
    assign tick = cnt_q == W'(DIV - 1);
    always_ff @(posedge clk or negedge rst)
        if (!rst) cnt_q <= '0;
        else      cnt_q <= tick ? '0 : cnt_q + W'(1);
endmodule

// File: rtl/seq_ser_tx.sv
// seq_ser_tx: valid/ready parallel word to MSB-first serial line, each bit held DIV clks.
// Define SEQ_SER_TX_PREAMBLE_EN to prefix every frame with the 1011 marker.
module seq_ser_tx
    import seq_link_pkg::*;
#(
    parameter int   DATA_W   = 8,
    parameter int   DIV      = DEFAULT_DIV,
    parameter logic IDLE_LVL = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              ser_out,
    output logic              bit_tick,
    output logic              busy,
    output logic              done
);
`ifdef SEQ_SER_TX_PREAMBLE_EN
    localparam int FW = DATA_W + PREAMBLE_W;
`else
    localparam int FW = DATA_W;
`endif
    localparam int CW = $clog2(FW + 1);
    state_t        state_q;
    logic [FW-1:0] sh_q, frame_d;
    logic [CW-1:0] bit_cnt_q;
    logic          ser_q, tick;
    seq_bit_tick #(.DIV(DIV)) u_tick (.clk(clk), .rst(rst), .tick(tick));
`ifdef SEQ_SER_TX_PREAMBLE_EN
    assign frame_d = {PREAMBLE, in_data};
`else
    assign frame_d = in_data;
`endif
    assign bit_tick = tick;
    assign busy     = state_q != IDLE;
    assign done     = state_q == SHIFT && bit_cnt_q == '0 && tick;
    assign in_ready = state_q == IDLE || done;
    assign ser_out  = ser_q;
    // ser_q only moves on tick edges, so the line is glitch-free between bit boundaries
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state_q   <= IDLE;
            sh_q      <= '0;
            bit_cnt_q <= '0;
            ser_q     <= IDLE_LVL;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    sh_q    <= frame_d;
                    state_q <= ARMED;
                end
                ARMED: if (tick) begin
                    ser_q     <= sh_q[FW-1];
                    sh_q      <= sh_q << 1;
                    bit_cnt_q <= CW'(FW - 1);
                    state_q   <= SHIFT;
                end
                SHIFT: if (tick) begin
                    if (bit_cnt_q != '0) begin
                        ser_q     <= sh_q[FW-1];
                        sh_q      <= sh_q << 1;
                        bit_cnt_q <= bit_cnt_q - CW'(1);
                    end else if (in_valid) begin
                        ser_q     <= frame_d[FW-1];
                        sh_q      <= frame_d << 1;
                        bit_cnt_q <= CW'(FW - 1);
                    end else begin
                        ser_q   <= IDLE_LVL;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_seq_ser_tx.sv
// tb_seq_ser_tx: random stimulus checked against a bit-window timing model of the transmitter.
module tb_seq_ser_tx;
    localparam int   DW   = 8;
    localparam int   DIV  = 3;
    localparam logic IDLE = 1'b0;
`ifdef SEQ_SER_TX_PREAMBLE_EN
    localparam int FW = DW + 4;
`else
    localparam int FW = DW;
`endif
    logic clk = 0, rst = 0, in_valid = 0, in_ready, ser_out, bit_tick, busy, done;
    logic [DW-1:0] in_data = '0;
    int total = 0, bad = 0;
    int c = 0, s_e = 0, end_e = 0;
    bit have = 0;
    logic [FW-1:0] fr;
    logic e_busy, e_ser, e_done, e_rdy, e_tick;

    seq_ser_tx #(.DATA_W(DW), .DIV(DIV), .IDLE_LVL(IDLE)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .ser_out(ser_out), .bit_tick(bit_tick), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s c=%0d got=%0h exp=%0h", tag, c, got, exp);
        end
    endtask

    function automatic logic [FW-1:0] frame_of(input logic [DW-1:0] d);
`ifdef SEQ_SER_TX_PREAMBLE_EN
        return {4'b1011, d};
`else
        return d;
`endif
    endfunction

    // A frame occupies edges [s_e, end_e); bit k of the frame is on the line for clks s_e+k*DIV ..
    task automatic model_eval();
        e_busy = have && c < end_e;
        e_ser  = (have && c >= s_e && c < end_e) ? fr[FW-1-(c-s_e)/DIV] : IDLE;
        e_done = have && c == end_e - 1;
        e_rdy  = !(have && c < end_e - 1);
        e_tick = (c % DIV) == DIV - 1;
    endtask

    task automatic step(input logic v, input logic [DW-1:0] d);
        int t;
        in_valid = v;
        in_data  = d;
        @(negedge clk);
        model_eval();
        chk("ser_out", ser_out, e_ser);
        chk("busy", busy, e_busy);
        chk("in_ready", in_ready, e_rdy);
        chk("done", done, e_done);
        chk("bit_tick", bit_tick, e_tick);
        if (v && e_rdy) begin
            fr = frame_of(d);
            if (e_done) s_e = c + 1;
            else begin
                t = c + 1;
                while (t % DIV != DIV - 1) t++;
                s_e = t + 1;
            end
            end_e = s_e + FW * DIV;
            have  = 1;
        end
        @(posedge clk);
        #1 c++;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_ser"}, ser_out, IDLE);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_rdy"}, in_ready, 1);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_tick"}, bit_tick, 0);
    endtask

    task automatic release_rst();
        @(posedge clk);
        #1 rst = 1;
        c = 0;
        have = 0;
    endtask

    task automatic rand_run(input int n, input int pct);
        for (int i = 0; i < n; i++) step($urandom_range(99) < pct, DW'($urandom));
    endtask

    initial begin
        #2 check_idle("rst0");
        repeat (2) @(negedge clk);
        check_idle("rst1");
        release_rst();
        step(0, 8'h00);
        step(1, 8'hB5);
        for (int i = 0; i < FW * DIV + 6; i++) step(0, DW'($urandom));
        for (int p = 0; p < DIV; p++) begin
            step(1, DW'($urandom));
            for (int i = 0; i < FW * DIV + DIV + p; i++) step(0, DW'($urandom));
        end
        step(1, 8'hFF);
        for (int i = 0; i < FW * DIV + 2; i++) step(1, 8'h00);
        for (int i = 0; i < FW * DIV + 4; i++) step(0, DW'($urandom));
        rand_run(300, 100);
        rand_run(400, 30);
        rand_run(400, 4);
        for (int i = 0; i < FW * DIV + DIV + 2; i++) step(0, DW'($urandom));
        step(1, 8'hA5);
        for (int i = 0; i < 3 * DIV + 2; i++) step(0, DW'($urandom));
        chk("pre_abort_busy", busy, 1);
        #2 rst = 0;
        #1 chk("abort_ser", ser_out, IDLE);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        @(negedge clk);
        check_idle("abort_hold");
        release_rst();
        step(1, 8'h3C);
        for (int i = 0; i < FW * DIV + DIV + 2; i++) step(0, DW'($urandom));
        rand_run(300, 50);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/seq_ser_tx.md
Name: seq_ser_tx

Overview:
- Serial transmitter for the bit-serial link consumed by the team's "1011" sequence detector.
- Accepts a parallel word over a valid/ready handshake and shifts it out MSB-first.
- Each bit is held for DIV system clocks, matching the divide-by-3 bit rate the detector samples at.
- Sits between a parallel producer and the detector's ser_in input.
- Operates entirely in the clk domain using a clock-enable tick; no derived clocks.

Parameters:
- DATA_W, 8, payload width in bits (min 1).
- DIV, 3, clk cycles per serial bit (min 2).
- IDLE_LVL, 1'b0, ser_out level when no frame is in flight.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low (asserted at 0).
- in_data  in  DATA_W  word to transmit.
- in_valid  in  1  producer has a word.
- in_ready  out  1  block accepts in_data this cycle.
- ser_out  out  1  serial line to the detector.
- bit_tick  out  1  one-clk pulse marking each bit boundary (div_cnt==DIV-1).
- busy  out  1  frame in flight (state != IDLE).
- done  out  1  one-clk pulse at the edge ending the last bit period of a frame.

Behaviour:
- Reset (rst=0, async) sets div_cnt=0, state=IDLE, shift register=0, bit_cnt=0. Outputs: ser_out=IDLE_LVL, in_ready=1, busy=0, done=0, bit_tick=0.
- Divider: div_cnt counts 0..DIV-1 and wraps. It free-runs from reset release regardless of state. tick = (div_cnt==DIV-1); bit_tick is combinational tick.
- FRAME_W = DATA_W, or DATA_W+4 with PREAMBLE_EN.
- States:
  - IDLE: in_ready=1. On in_valid: latch frame, go to ARMED.
  - ARMED: waits for tick, which aligns the first bit to the bit grid. At the tick edge: ser_out<=frame MSB, bit_cnt<=FRAME_W-1, go to SHIFT. Latency from accept to first bit is 1..DIV clks.
  - SHIFT: ser_out changes only on tick edges.
    - On tick with bit_cnt>0: shift left, drive next bit, decrement bit_cnt.
    - On tick with bit_cnt==0: the last bit's period ends and done pulses at this edge.
      - If in_valid (gapless back-to-back): load the new frame, ser_out<=its MSB, bit_cnt<=FRAME_W-1, stay in SHIFT.
      - Else: ser_out<=IDLE_LVL, go to IDLE.
- in_ready = (state==IDLE) | (state==SHIFT & bit_cnt==0 & tick). Handshake completes at the edge where in_valid & in_ready.
- in_data is sampled only at acceptance. Later changes to in_data do not affect the frame in flight.
- in_valid without in_ready: the word is held by the producer, not dropped. The block does not require in_valid to stay high after acceptance.
- Every bit, including the first and last, is held exactly DIV clks. No glitches on ser_out between ticks.
- done and an in_ready-accept can occur on the same edge, and both are honoured.
- rst asserted mid-frame: immediate abort. ser_out goes to IDLE_LVL, no done pulse, and the divider restarts from 0.

Optional Feature:
- Macro: SEQ_SER_TX_PREAMBLE_EN.
- Defined: every frame, including gapless ones, is prefixed MSB-first with the 4-bit marker 1,0,1,1. The detector therefore asserts once per frame at the marker; FRAME_W=DATA_W+4.
- Undefined: payload only; FRAME_W=DATA_W and no marker bits.

Decomposition:
- Shared package seq_link_pkg holds:
  - PREAMBLE = 4'b1011 and PREAMBLE_W = 4;
  - the state enum (IDLE, ARMED, SHIFT) as a 2-bit typedef;
  - the default DIV = 3, shared with the detector side.
- One sub-module, seq_bit_tick: the free-running modulo-DIV counter producing tick, reusable by the receiver.

Test Plan:
- Reset, then send 8'hB5 with the macro undefined and DIV=3 → ser_out = 1,0,1,1,0,1,0,1, each held 3 clks. done pulses once, 24 clks after the first bit edge; ser_out then returns to 0 and busy=0.
- Accept on each of the 3 div_cnt phases → first-bit latency of 3, 2 and 1 clks respectively. Bit edges always coincide with bit_tick.
- Gapless stream: 8'hFF then 8'h00 with in_valid held high → 16 contiguous bit periods, no IDLE gap. The second handshake occurs on the same edge as the first done.
- SEQ_SER_TX_PREAMBLE_EN defined, send 8'h00 → ser_out = 1,0,1,1 followed by eight 0s. The looped-back detector asserts out exactly once.
- Assert rst (0) at bit 3 of 8'hA5 → ser_out=0 and busy=0 asynchronously, with no done pulse. After release, a new 8'h3C transmits correctly from bit 7.
- Toggle in_data while busy; hold in_valid low between frames → transmitted bits match the value at acceptance, and in_ready stays 0 in ARMED and mid-SHIFT.
